hazard_controller: RTL and testbench

Pipeline hazard controller for the 5-stage RISC-V core. It works alongside `forwarding_unit`: forwarding covers ALU-to-ALU dependences, and this block handles the hazards forwarding cannot. Those are load-use stalls, taken-branch/jump flushes, and data-memory wait states. It drives the write-enable and flush controls of the PC and the pipeline registers, detects data-memory timeouts and keeps two performance counters.

---
 rtl/hazard_controller_pkg.sv | 33 +++
 rtl/hazard_controller_perf_counter.sv | 24 ++
 rtl/hazard_controller.sv | 134 +++++++++++++
 tb/tb_hazard_controller.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_controller_pkg.sv
// Shared types for the pipeline hazard controller: FSM state, register-zero
// constant and the bundle of pipeline control signals.
package hazard_pkg;

   typedef enum logic {
      RUN  = 1'b0,
      WAIT = 1'b1
   } hz_state_t;

   localparam logic [4:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic pc_write;
      logic if_id_write;
      logic if_id_flush;
      logic id_ex_write;
      logic id_ex_flush;
      logic ex_mem_write;
      logic mem_wb_bubble;
   } ctrl_t;

   // Free-running pipeline: every stage advances, nothing squashed.
   localparam ctrl_t CTRL_DEFAULT = '{
      pc_write:      1'b1,
      if_id_write:   1'b1,
      if_id_flush:   1'b0,
      id_ex_write:   1'b1,
      id_ex_flush:   1'b0,
      ex_mem_write:  1'b1,
      mem_wb_bubble: 1'b0
   };

endpackage

// File: rtl/hazard_controller_perf_counter.sv
// Wrapping event counter used for the hazard performance statistics.
module perf_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] r_count;

   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
      end else if (inc) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign count = r_count;

endmodule

// File: rtl/hazard_controller.sv
// Hazard controller for the 5-stage core: load-use stalls, branch flushes,
// data-memory freezes with timeout detection, plus stall/flush counters.
module hazard_controller
   import hazard_pkg::*;
#(
   parameter int MAX_WAIT = 16,
   parameter int CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_raddr1,
   input  logic [4:0]       id_raddr2,
   input  logic             id_uses_rs1,
   input  logic             id_uses_rs2,
   input  logic             id_ex_mem_read,
   input  logic [4:0]       id_ex_waddr,
   input  logic             ex_branch_taken,
   input  logic             dmem_req,
   input  logic             dmem_ready,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             if_id_flush,
   output logic             id_ex_write,
   output logic             id_ex_flush,
   output logic             ex_mem_write,
   output logic             mem_wb_bubble,
   output logic             mem_timeout,
   output logic             mem_error,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count
);

   // Counter must be able to hold MAX_WAIT itself, the saturation value.
   localparam int WCNT_W = $clog2(MAX_WAIT + 1);

   hz_state_t         r_state;
   hz_state_t         w_state_next;
   logic [WCNT_W-1:0] r_wait_cnt;
   logic              r_mem_error;
   logic              r_mem_timeout;
   logic              w_mem_stall;
   logic              w_load_use;
   logic              w_branch_flush;
   logic              w_timeout_hit;
   ctrl_t             w_ctrl;

   assign w_mem_stall = dmem_req && !dmem_ready;

   assign w_load_use = id_ex_mem_read && (id_ex_waddr != REG_ZERO) &&
                       ((id_uses_rs1 && (id_raddr1 == id_ex_waddr)) ||
                        (id_uses_rs2 && (id_raddr2 == id_ex_waddr)));

   assign w_branch_flush = !rst && ex_branch_taken && !w_mem_stall;

   // Priority: reset, memory freeze, branch flush, load-use stall.
   always_comb begin
      // NOTE: default assignment first so no path through this block infers a latch.
      w_ctrl = CTRL_DEFAULT;
      if (rst) begin
         w_ctrl = CTRL_DEFAULT;
      end else if (w_mem_stall) begin
         w_ctrl = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                    id_ex_write: 1'b0, id_ex_flush: 1'b0, ex_mem_write: 1'b0,
                    mem_wb_bubble: 1'b1};
      end else if (ex_branch_taken) begin
         w_ctrl.if_id_flush = 1'b1;
         w_ctrl.id_ex_flush = 1'b1;
      end else if (w_load_use) begin
         w_ctrl.pc_write    = 1'b0;
         w_ctrl.if_id_write = 1'b0;
         w_ctrl.id_ex_flush = 1'b1;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         RUN:     if (w_mem_stall) w_state_next = WAIT;
         WAIT:    if (dmem_ready || !dmem_req) w_state_next = RUN;
         default: w_state_next = RUN;
      endcase
   end

   assign w_timeout_hit = (r_state == WAIT) && w_mem_stall &&
                          (r_wait_cnt == WCNT_W'(MAX_WAIT - 1));

   // wait_cnt moves past MAX_WAIT-1 after the hit, so one pulse per wait.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= RUN;
         r_wait_cnt    <= '0;
         r_mem_error   <= 1'b0;
         r_mem_timeout <= 1'b0;
      end else begin
         r_state       <= w_state_next;
         r_mem_timeout <= w_timeout_hit;
         if (w_timeout_hit) begin
            r_mem_error <= 1'b1;
         end
         if (r_state == RUN) begin
            r_wait_cnt <= w_mem_stall ? WCNT_W'(1) : '0;
         end else if (w_state_next == RUN) begin
            r_wait_cnt <= '0;
         end else if (r_wait_cnt < WCNT_W'(MAX_WAIT)) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
         end
      end
   end

   assign pc_write      = w_ctrl.pc_write;
   assign if_id_write   = w_ctrl.if_id_write;
   assign if_id_flush   = w_ctrl.if_id_flush;
   assign id_ex_write   = w_ctrl.id_ex_write;
   assign id_ex_flush   = w_ctrl.id_ex_flush;
   assign ex_mem_write  = w_ctrl.ex_mem_write;
   assign mem_wb_bubble = w_ctrl.mem_wb_bubble;
   assign mem_timeout   = r_mem_timeout && !rst;
   assign mem_error     = r_mem_error;

   perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (!w_ctrl.pc_write),
      .count (stall_cycles)
   );

   perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (w_branch_flush),
      .count (flush_count)
   );

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller with MAX_WAIT=4 and CNT_W=4 so the
// timeout and counter wrap are reachable in a few cycles.
module tb_hazard_controller;
   import hazard_pkg::*;

   localparam int MAX_WAIT = 4;
   localparam int CNT_W    = 4;

   // Packed order: pc_write, if_id_write, if_id_flush, id_ex_write,
   // id_ex_flush, ex_mem_write, mem_wb_bubble.
   localparam logic [6:0] C_DEF = 7'b1101010;
   localparam logic [6:0] C_LU  = 7'b0001110;
   localparam logic [6:0] C_BR  = 7'b1111110;
   localparam logic [6:0] C_FRZ = 7'b0000001;

   logic             clk = 1'b0;
   logic             rst;
   logic [4:0]       id_raddr1, id_raddr2, id_ex_waddr;
   logic             id_uses_rs1, id_uses_rs2, id_ex_mem_read;
   logic             ex_branch_taken, dmem_req, dmem_ready;
   logic             pc_write, if_id_write, if_id_flush, id_ex_write;
   logic             id_ex_flush, ex_mem_write, mem_wb_bubble;
   logic             mem_timeout, mem_error;
   logic [CNT_W-1:0] stall_cycles, flush_count;
   logic [6:0]       obs;

   int n_pass  = 0;
   int n_total = 0;

   hazard_controller #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
      .clk             (clk),
      .rst             (rst),
      .id_raddr1       (id_raddr1),
      .id_raddr2       (id_raddr2),
      .id_uses_rs1     (id_uses_rs1),
      .id_uses_rs2     (id_uses_rs2),
      .id_ex_mem_read  (id_ex_mem_read),
      .id_ex_waddr     (id_ex_waddr),
      .ex_branch_taken (ex_branch_taken),
      .dmem_req        (dmem_req),
      .dmem_ready      (dmem_ready),
      .pc_write        (pc_write),
      .if_id_write     (if_id_write),
      .if_id_flush     (if_id_flush),
      .id_ex_write     (id_ex_write),
      .id_ex_flush     (id_ex_flush),
      .ex_mem_write    (ex_mem_write),
      .mem_wb_bubble   (mem_wb_bubble),
      .mem_timeout     (mem_timeout),
      .mem_error       (mem_error),
      .stall_cycles    (stall_cycles),
      .flush_count     (flush_count)
   );

   assign obs = {pc_write, if_id_write, if_id_flush, id_ex_write,
                 id_ex_flush, ex_mem_write, mem_wb_bubble};

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      id_raddr1 = 5'd0;  id_raddr2 = 5'd0;  id_ex_waddr = 5'd0;
      id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; id_ex_mem_read = 1'b0;
      ex_branch_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
   endtask

   task automatic set_load_use();
      id_ex_mem_read = 1'b1; id_ex_waddr = 5'd5;
      id_raddr2 = 5'd5;      id_uses_rs2 = 1'b1;
   endtask

   task automatic apply_reset();
      clear_inputs();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      clear_inputs();
      set_load_use();
      ex_branch_taken = 1'b1; dmem_req = 1'b1;
      rst = 1'b1;
      #1;
      n_total++;
      if (obs !== C_DEF) $display("FAIL reset_ctrl got %b want %b", obs, C_DEF); else n_pass++;
      n_total++;
      if (mem_timeout !== 1'b0) $display("FAIL reset_timeout got %b want 0", mem_timeout); else n_pass++;
      tick();
      tick();
      n_total++;
      if ({stall_cycles, flush_count, mem_error} !== '0)
         $display("FAIL reset_regs got stall=%0d flush=%0d err=%b want 0/0/0", stall_cycles, flush_count, mem_error);
      else n_pass++;
      rst = 1'b0;
      clear_inputs();
      #1;
   endtask

   task automatic test_load_use();
      apply_reset();
      set_load_use();
      #1;
      n_total++;
      if (obs !== C_LU) $display("FAIL lu_rs2_ctrl got %b want %b", obs, C_LU); else n_pass++;
      tick();
      n_total++;
      if (stall_cycles !== 4'd1) $display("FAIL lu_stall_cnt got %0d want 1", stall_cycles); else n_pass++;
      id_ex_waddr = 5'd0; id_raddr2 = 5'd0;
      #1;
      n_total++;
      if (obs !== C_DEF) $display("FAIL lu_x0_ctrl got %b want %b", obs, C_DEF); else n_pass++;
      tick();
      id_ex_waddr = 5'd5; id_raddr2 = 5'd5; id_uses_rs2 = 1'b0;
      #1;
      n_total++;
      if (obs !== C_DEF) $display("FAIL lu_noread_ctrl got %b want %b", obs, C_DEF); else n_pass++;
      tick();
      n_total++;
      if (stall_cycles !== 4'd1) $display("FAIL lu_nostall_cnt got %0d want 1", stall_cycles); else n_pass++;
      id_raddr1 = 5'd5; id_uses_rs1 = 1'b1;
      #1;
      n_total++;
      if (obs !== C_LU) $display("FAIL lu_rs1_ctrl got %b want %b", obs, C_LU); else n_pass++;
      tick();
      n_total++;
      if (stall_cycles !== 4'd2) $display("FAIL lu_rs1_cnt got %0d want 2", stall_cycles); else n_pass++;
      clear_inputs();
   endtask

   task automatic test_branch_beats_load_use();
      apply_reset();
      set_load_use();
      ex_branch_taken = 1'b1;
      #1;
      n_total++;
      if (obs !== C_BR) $display("FAIL br_lu_ctrl got %b want %b", obs, C_BR); else n_pass++;
      tick();
      clear_inputs();
      #1;
      n_total++;
      if ({flush_count, stall_cycles} !== {4'd1, 4'd0})
         $display("FAIL br_lu_cnt got flush=%0d stall=%0d want 1/0", flush_count, stall_cycles);
      else n_pass++;
   endtask

   task automatic test_mem_wait();
      apply_reset();
      dmem_req = 1'b1; dmem_ready = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         #1;
         n_total++;
         if (obs !== C_FRZ) $display("FAIL wait_frz_c%0d got %b want %b", c, obs, C_FRZ); else n_pass++;
         tick();
      end
      n_total++;
      if (dut.r_state !== WAIT) $display("FAIL wait_state got %0d want WAIT", dut.r_state); else n_pass++;
      dmem_ready = 1'b1;
      #1;
      n_total++;
      if (obs !== C_DEF) $display("FAIL wait_release_ctrl got %b want %b", obs, C_DEF); else n_pass++;
      tick();
      clear_inputs();
      #1;
      n_total++;
      if (dut.r_state !== RUN) $display("FAIL wait_back_run got %0d want RUN", dut.r_state); else n_pass++;
      n_total++;
      if (stall_cycles !== 4'd3) $display("FAIL wait_stall_cnt got %0d want 3", stall_cycles); else n_pass++;
   endtask

   task automatic test_branch_during_freeze();
      apply_reset();
      ex_branch_taken = 1'b1; dmem_req = 1'b1; dmem_ready = 1'b0;
      for (int c = 1; c <= 2; c++) begin
         #1;
         n_total++;
         if (obs !== C_FRZ) $display("FAIL brfrz_c%0d got %b want %b", c, obs, C_FRZ); else n_pass++;
         tick();
      end
      dmem_ready = 1'b1;
      #1;
      n_total++;
      if (obs !== C_BR) $display("FAIL brfrz_release got %b want %b", obs, C_BR); else n_pass++;
      tick();
      clear_inputs();
      #1;
      n_total++;
      if (obs !== C_DEF) $display("FAIL brfrz_after got %b want %b", obs, C_DEF); else n_pass++;
      tick();
      n_total++;
      if ({flush_count, stall_cycles} !== {4'd1, 4'd2})
         $display("FAIL brfrz_cnt got flush=%0d stall=%0d want 1/2", flush_count, stall_cycles);
      else n_pass++;
   endtask

   task automatic test_timeout();
      apply_reset();
      dmem_req = 1'b1; dmem_ready = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         #1;
         n_total++;
         if ({mem_timeout, mem_error} !== {(c == 5), (c >= 5)})
            $display("FAIL tmo_c%0d got tmo=%b err=%b want %b/%b", c, mem_timeout, mem_error, (c == 5), (c >= 5));
         else n_pass++;
         tick();
      end
      dmem_ready = 1'b1;
      tick();
      clear_inputs();
      tick();
      tick();
      n_total++;
      if ({mem_error, mem_timeout} !== 2'b10)
         $display("FAIL tmo_sticky got err=%b tmo=%b want 1/0", mem_error, mem_timeout);
      else n_pass++;
      n_total++;
      if (stall_cycles !== 4'd10) $display("FAIL tmo_stall_cnt got %0d want 10", stall_cycles); else n_pass++;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      n_total++;
      if (mem_error !== 1'b0) $display("FAIL tmo_rst_clear got %b want 0", mem_error); else n_pass++;
   endtask

   task automatic test_reset_mid_wait();
      apply_reset();
      dmem_req = 1'b1; dmem_ready = 1'b0;
      ex_branch_taken = 1'b1;
      tick();
      rst = 1'b1;
      #1;
      n_total++;
      if ({obs, mem_timeout} !== {C_DEF, 1'b0})
         $display("FAIL rstwait_ctrl got %b/%b want %b/0", obs, mem_timeout, C_DEF);
      else n_pass++;
      tick();
      rst = 1'b0;
      clear_inputs();
      #1;
      n_total++;
      if (dut.r_state !== RUN) $display("FAIL rstwait_state got %0d want RUN", dut.r_state); else n_pass++;
      n_total++;
      if ({stall_cycles, flush_count, mem_error} !== '0)
         $display("FAIL rstwait_regs got stall=%0d flush=%0d err=%b want 0/0/0", stall_cycles, flush_count, mem_error);
      else n_pass++;
      for (int c = 1; c <= 5; c++) begin
         tick();
         n_total++;
         if (mem_timeout !== 1'b0) $display("FAIL rstwait_tmo_c%0d got %b want 0", c, mem_timeout); else n_pass++;
      end
   endtask

   task automatic test_wrap();
      apply_reset();
      set_load_use();
      for (int c = 1; c <= 17; c++) tick();
      clear_inputs();
      #1;
      n_total++;
      if (stall_cycles !== 4'd1) $display("FAIL wrap_stall_cnt got %0d want 1", stall_cycles); else n_pass++;
   endtask

   initial begin
      clear_inputs();
      rst = 1'b1;
      tick();
      test_reset();
      test_load_use();
      test_branch_beats_load_use();
      test_mem_wait();
      test_branch_during_freeze();
      test_timeout();
      test_reset_mid_wait();
      test_wrap();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
